systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- North-edge driver for the weight-stationary PE array. It is the transmitter side of each PE's north input and load_weight pins.
- Buffers one full weight tile, then bursts it down every column gapless with load_weight high.
- Flushes stale weights out of the out_s chains, then streams activation vectors with a per-column diagonal skew, so partial sums meet the activations along each row.

Parameters:
- ROWS, 4, PE rows per column (weight beats per tile).
- COLS, 4, PE columns (elements per vector).
- DATA_W, 8, signed element width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- w_valid  in  1  weight beat valid
- w_ready  out  1  weight beat accept
- w_data  in  COLS*DATA_W  one weight row; element j in bits [j*DATA_W +: DATA_W]; beat k = array row k
- a_valid  in  1  activation vector valid
- a_ready  out  1  activation accept
- a_data  in  COLS*DATA_W  activation vector, same packing
- a_last  in  1  final vector of batch (qualified by handshake)
- array_n  out  COLS*DATA_W  to in_n of top PE in each column
- load_weight  out  1  to all PEs
- issue_valid  out  1  pulses when column 0 carries a real vector
- issue_last  out  1  with issue_valid on the a_last vector
- busy  out  1  high in any state except COLLECT

Behaviour:
Reset and outputs:
- rst_n low: state=COLLECT, beat count=0, weight buffer cleared, skew lines cleared.
- All registered outputs 0 (array_n, load_weight, issue_valid, issue_last).
- Reset mid-operation abandons the tile and the batch; no partial recovery.
- array_n, load_weight, issue_* are registered: the effect of cycle t appears at t+1.

States:
- COLLECT: w_ready=1, a_ready=0.
  - Each w handshake stores w_data in buf[count] and increments count.
  - On the handshake with count=ROWS-1: go to LOAD, count=0.
  - array_n=0, load_weight=0.
- LOAD: exactly ROWS cycles, no stalls.
  - Cycle k (0..ROWS-1): array_n=buf[ROWS-1-k] for all columns, skew bypassed, load_weight=1.
  - Result: PE row r latches buf[r].
  - w_ready=0, a_ready=0.
- SETTLE: exactly ROWS cycles.
  - array_n=0, load_weight=0.
  - Flushes weight copies out of out_s registers.
  - Downstream ignores east outputs produced in this window.
- STREAM: a_ready=1.
  - On an a handshake: element j enters a j-stage delay line (column 0 zero-delay) and issue_valid=1.
  - Required timing: element j appears on array_n[j] at cycle t+1+j.
  - Cycles without a handshake inject zeros (bubbles); issue_valid=0.
  - On a handshake with a_last=1: issue_last=1 and go to DRAIN.
- DRAIN: COLS-1 cycles.
  - Zeros shifted in, a_ready=0, so all skew lines are empty.
  - Then go to COLLECT, count=0.
  - With COLS=1, DRAIN is skipped.

Boundary rules:
- w_valid outside COLLECT is ignored (w_ready=0). A new tile cannot overlap a batch.
- a_valid outside STREAM is ignored.
- Skew lines are guaranteed zero on every LOAD entry. They are never read during LOAD.
- Data is passed unmodified: no arithmetic, no sign change.

Decomposition:
- Shared package systolic_pkg:
  - state enum COLLECT/LOAD/SETTLE/STREAM/DRAIN
  - DATA_W and accumulator width (24) constants
  - element-slice helper function
- One sub-module: skew_delay_line (parameter DEPTH, DATA_W; async active-low reset).
  - Instantiated per column with DEPTH=j.
  - DEPTH=0 is a wire.

Test Plan:
1. Reset: hold rst_n low with random inputs -> all outputs 0, w_ready=1, busy=0. Assert rst_n mid-cycle -> outputs clear without a clock edge.
2. Weight load, ROWS=COLS=4, beat k element j = 16k+j:
   - After the 4th handshake: load_weight=1 for exactly 4 cycles, array_n rows in order 0x30..,0x20..,0x10..,0x00..
   - Then 4 zero cycles, then a_ready=1.
3. Single vector [1,2,-3,-128] with a_last, accepted at cycle t:
   - array_n[0]=1 at t+1, [1]=2 at t+2, [2]=-3 at t+3, [3]=-128 at t+4, zeros otherwise.
   - issue_valid/issue_last at t+1.
   - COLLECT reached after 3 DRAIN cycles.
4. Bubbles: a_valid pattern 1,0,0,1,1 -> zeros in gap slots, issue_valid exactly 3 pulses, ordering preserved.
5. Protocol: w_valid held high during STREAM -> w_ready stays 0 and the buffer is unchanged. Second tile loads correctly after DRAIN.
6. Golden and reset recovery:
   - Feeder driving a 4x4 PE-array model with random signed W and 8 vectors including -128*-128 -> east sums equal W·x per row, 24-bit sign-extended.
   - Repeat with rst_n pulsed mid-LOAD -> clean restart, correct results for the next tile.

Source files
------------

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared state encoding, widths and element-slice helper for
//                the systolic array north-edge feeder.
//  Revision    : 1.0  initial release
// ============================================================================
package systolic_pkg;

    // Feeder state encoding
    localparam logic [2:0] S_COLLECT = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_STREAM  = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    // Default element width and PE accumulator width
    localparam int C_DATA_W = 8;
    localparam int C_ACC_W  = 24;

    // LSB position of element idx inside a packed vector of width-bit elements
    function automatic int elem_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_feeder_skew_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : skew_delay_line
//  Description : Fixed-latency shift register giving one column its diagonal
//                skew. DEPTH=0 degenerates to a plain wire.
//  Revision    : 1.0  initial release
// ============================================================================
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Column 0 carries no skew; clock and reset are not needed here
            logic w_unused;
            assign w_unused = clk ^ rst_n;
            assign o_data   = i_data;
        end else begin : g_shift
            logic [DATA_W-1:0] r_stage [DEPTH];

            // Shift one element per cycle; reset empties every stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_feeder
//  Description : North-edge driver for a weight-stationary PE array. Buffers
//                a weight tile, bursts it down the columns with load_weight,
//                flushes the out_s chains, then streams skewed activations.
//  Revision    : 1.0  initial release
// ============================================================================
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = C_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [COLS*DATA_W-1:0] w_data,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [COLS*DATA_W-1:0] a_data,
    input  logic                   a_last,
    output logic [COLS*DATA_W-1:0] array_n,
    output logic                   load_weight,
    output logic                   issue_valid,
    output logic                   issue_last,
    output logic                   busy
);

    localparam int C_VEC_W = COLS * DATA_W;
    localparam int C_MAXN  = (ROWS > COLS) ? ROWS : COLS;
    localparam int C_CNT_W = $clog2(C_MAXN) + 1;

    localparam logic [C_CNT_W-1:0] C_ROWS_LAST  = C_CNT_W'(ROWS - 1);
    localparam logic [C_CNT_W-1:0] C_DRAIN_LAST = C_CNT_W'((COLS > 1) ? (COLS - 2) : 0);
    localparam logic [C_CNT_W-1:0] C_ONE        = C_CNT_W'(1);

    logic [2:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_VEC_W-1:0] r_buf [ROWS];

    logic [C_VEC_W-1:0] r_array_n;
    logic               r_load_weight;
    logic               r_issue_valid;
    logic               r_issue_last;

    logic               w_wt_fire;
    logic               w_act_fire;
    logic [C_VEC_W-1:0] w_load_row;
    logic [C_VEC_W-1:0] w_skew_in;
    logic [C_VEC_W-1:0] w_skew_out;

    assign w_ready    = (r_state == S_COLLECT);
    assign a_ready    = (r_state == S_STREAM);
    assign busy       = (r_state != S_COLLECT);
    assign w_wt_fire  = w_valid & w_ready;
    assign w_act_fire = a_valid & a_ready;

    // Bubbles enter the skew lines as zeros
    assign w_skew_in  = w_act_fire ? a_data : '0;

    // Rows go out bottom-first so that row r ends up holding buf[r]
    always_comb begin
        w_load_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r_cnt == C_CNT_W'(ROWS - 1 - r)) begin
                w_load_row = r_buf[r];
            end
        end
    end

    generate
        for (genvar j = 0; j < COLS; j++) begin : g_col
            skew_delay_line #(
                .DEPTH  (j),
                .DATA_W (DATA_W)
            ) u_skew (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_data (w_skew_in[elem_lsb(j, DATA_W) +: DATA_W]),
                .o_data (w_skew_out[elem_lsb(j, DATA_W) +: DATA_W])
            );
        end
    endgenerate

    // Sequencing: collect tile, load, settle, stream batch, drain skew lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_wt_fire) begin
                        if (r_cnt == C_ROWS_LAST) begin
                            r_state <= S_LOAD;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + C_ONE;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_cnt == C_ROWS_LAST) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == C_ROWS_LAST) begin
                        r_state <= S_STREAM;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                S_STREAM: begin
                    if (w_act_fire && a_last) begin
                        r_state <= (COLS > 1) ? S_DRAIN : S_COLLECT;
                        r_cnt   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == C_DRAIN_LAST) begin
                        r_state <= S_COLLECT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Weight tile buffer: beat k of the tile lands in row k
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                r_buf[r] <= '0;
            end
        end else if (w_wt_fire) begin
            for (int r = 0; r < ROWS; r++) begin
                if (r_cnt == C_CNT_W'(r)) begin
                    r_buf[r] <= w_data;
                end
            end
        end
    end

    // Registered north-edge outputs; LOAD bypasses the skew lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_array_n     <= '0;
            r_load_weight <= 1'b0;
            r_issue_valid <= 1'b0;
            r_issue_last  <= 1'b0;
        end else begin
            r_load_weight <= (r_state == S_LOAD);
            r_issue_valid <= w_act_fire;
            r_issue_last  <= w_act_fire & a_last;
            if (r_state == S_LOAD) begin
                r_array_n <= w_load_row;
            end else if ((r_state == S_STREAM) || (r_state == S_DRAIN)) begin
                r_array_n <= w_skew_out;
            end else begin
                r_array_n <= '0;
            end
        end
    end

    assign array_n     = r_array_n;
    assign load_weight = r_load_weight;
    assign issue_valid = r_issue_valid;
    assign issue_last  = r_issue_last;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_feeder
//  Description : Self-checking bench for systolic_feeder with a timeline
//                reference model and a downstream 4x4 PE-array model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_systolic_feeder;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int VW   = COLS * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [VW-1:0] w_data = '0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [VW-1:0] a_data = '0;
    logic          a_last = 1'b0;
    logic [VW-1:0] array_n;
    logic          load_weight;
    logic          issue_valid;
    logic          issue_last;
    logic          busy;

    always #5 clk = ~clk;

    systolic_feeder #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_data      (w_data),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_data      (a_data),
        .a_last      (a_last),
        .array_n     (array_n),
        .load_weight (load_weight),
        .issue_valid (issue_valid),
        .issue_last  (issue_last),
        .busy        (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int iv_count = 0;
    bit hold_w = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int el(input logic [VW-1:0] v, input int j);
        logic signed [DW-1:0] t;
        t = v[j*DW +: DW];
        return int'(t);
    endfunction

    // ---------------- reference model: per-cycle timeline of outputs -------
    localparam int P_COLLECT = 0;
    localparam int P_WAIT    = 1;
    localparam int P_STREAM  = 2;
    localparam int P_DRAIN   = 3;

    int            phase, beats, stream_at, collect_at;
    logic [VW-1:0] wbuf [ROWS];
    logic [VW-1:0] e_an [64];
    bit            e_lw [64];
    bit            e_iv [64];
    bit            e_il [64];
    int            g_val [64][ROWS];
    bit            g_en  [64][ROWS];

    task automatic model_clear();
        phase = P_COLLECT; beats = 0; stream_at = 0; collect_at = 0;
        for (int r = 0; r < ROWS; r++) wbuf[r] = '0;
        for (int i = 0; i < 64; i++) begin
            e_an[i] = '0; e_lw[i] = 0; e_iv[i] = 0; e_il[i] = 0;
            for (int r = 0; r < ROWS; r++) begin g_val[i][r] = 0; g_en[i][r] = 0; end
        end
    endtask

    task automatic model_step(input int c);
        int idx, y;
        case (phase)
            P_COLLECT: if (w_valid) begin
                wbuf[beats] = w_data;
                beats++;
                if (beats == ROWS) begin
                    for (int k = 0; k < ROWS; k++) begin
                        idx = (c + 2 + k) & 63;
                        e_an[idx] = wbuf[ROWS-1-k];
                        e_lw[idx] = 1;
                    end
                    stream_at = c + 1 + 2*ROWS;
                    phase = P_WAIT;
                    beats = 0;
                end
            end
            P_WAIT: if (c + 1 == stream_at) phase = P_STREAM;
            P_STREAM: if (a_valid) begin
                for (int j = 0; j < COLS; j++) begin
                    idx = (c + 1 + j) & 63;
                    e_an[idx][j*DW +: DW] = a_data[j*DW +: DW];
                end
                e_iv[(c+1) & 63] = 1;
                e_il[(c+1) & 63] = a_last;
                for (int r = 0; r < ROWS; r++) begin
                    y = 0;
                    for (int j = 0; j < COLS; j++) y += el(wbuf[r], j) * el(a_data, j);
                    idx = (c + 1 + COLS + r) & 63;
                    g_val[idx][r] = y;
                    g_en[idx][r]  = 1;
                end
                if (a_last) begin
                    if (COLS == 1) phase = P_COLLECT;
                    else begin collect_at = c + COLS; phase = P_DRAIN; end
                end
            end
            P_DRAIN: if (c + 1 == collect_at) phase = P_COLLECT;
            default: phase = P_COLLECT;
        endcase
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clear();
            else model_step(cyc);
        end
    end

    // ---------------- downstream weight-stationary PE array ----------------
    int pw [ROWS][COLS];
    int po [ROWS][COLS];
    int pp [ROWS][COLS];

    task automatic pe_update();
        int npw [ROWS][COLS];
        int npo [ROWS][COLS];
        int npp [ROWS][COLS];
        int inn;
        for (int r = 0; r < ROWS; r++) begin
            for (int j = 0; j < COLS; j++) begin
                inn = (r == 0) ? el(array_n, j) : po[r-1][j];
                npo[r][j] = inn;
                npp[r][j] = ((j == 0) ? 0 : pp[r][j-1]) + pw[r][j] * inn;
                npw[r][j] = load_weight ? inn : pw[r][j];
            end
        end
        pw = npw; po = npo; pp = npp;
    endtask

    // ---------------- compare process ----------------
    initial begin
        int i;
        logic signed [23:0] e24;
        for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < COLS; j++) begin pw[r][j] = 0; po[r][j] = 0; pp[r][j] = 0; end
        forever begin
            @(negedge clk);
            i = cyc & 63;
            chk("array_n",     64'(array_n),     64'(e_an[i]));
            chk("load_weight", 64'(load_weight), 64'(e_lw[i]));
            chk("issue_valid", 64'(issue_valid), 64'(e_iv[i]));
            chk("issue_last",  64'(issue_last),  64'(e_il[i]));
            chk("w_ready",     64'(w_ready),     64'(phase == P_COLLECT));
            chk("a_ready",     64'(a_ready),     64'(phase == P_STREAM));
            chk("busy",        64'(busy),        64'(phase != P_COLLECT));
            for (int r = 0; r < ROWS; r++) begin
                if (g_en[i][r]) begin
                    e24 = pp[r][COLS-1][23:0];
                    chk($sformatf("east_row%0d", r), 64'(e24), 64'(g_val[i][r]));
                end
                g_en[i][r] = 0;
            end
            e_an[i] = '0; e_lw[i] = 0; e_iv[i] = 0; e_il[i] = 0;
            if (rst_n && issue_valid) iv_count++;
            pe_update();
        end
    end

    // ---------------- stimulus helpers (enter and leave at negedge) --------
    logic [VW-1:0] tile [ROWS];

    task automatic idle(input int n);
        repeat (n) begin
            w_valid = hold_w; w_data = $urandom;
            a_valid = 1'b0; a_data = $urandom; a_last = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic send_w(input logic [VW-1:0] d);
        int n = 0;
        w_valid = 1'b1; w_data = d;
        a_valid = 1'b0; a_data = $urandom;
        while (!w_ready) begin
            @(negedge clk);
            n++;
            if (n > 100) begin chk("w_handshake_timeout", 64'(n), 64'(0)); break; end
        end
        @(negedge clk);
        w_valid = 1'b0; w_data = $urandom;
    endtask

    task automatic send_a(input logic [VW-1:0] d, input logic last);
        int n = 0;
        a_valid = 1'b1; a_data = d; a_last = last;
        w_valid = hold_w; w_data = $urandom;
        while (!a_ready) begin
            @(negedge clk);
            n++;
            if (n > 100) begin chk("a_handshake_timeout", 64'(n), 64'(0)); break; end
        end
        @(negedge clk);
        a_valid = 1'b0; a_data = $urandom; a_last = 1'($urandom_range(0, 1));
    endtask

    task automatic load_tile();
        for (int k = 0; k < ROWS; k++) send_w(tile[k]);
    endtask

    task automatic rand_tile();
        for (int k = 0; k < ROWS; k++) tile[k] = $urandom;
    endtask

    task automatic stream_batch(input int n, input bit neg_corner);
        logic [VW-1:0] v;
        for (int m = 0; m < n; m++) begin
            v = $urandom;
            if (neg_corner && m == 0) v[DW-1:0] = 8'h80;
            idle($urandom_range(0, 2));
            send_a(v, (m == n - 1));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [VW-1:0] lit_rows [ROWS];
        lit_rows[0] = 32'h33323130; lit_rows[1] = 32'h23222120;
        lit_rows[2] = 32'h13121110; lit_rows[3] = 32'h03020100;

        // Reset with random activity on the inputs
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            w_valid = 1'($urandom_range(0, 1)); w_data = $urandom;
            a_valid = 1'($urandom_range(0, 1)); a_data = $urandom;
            a_last  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("rst_array_n", 64'(array_n), 64'(0));
        chk("rst_load_weight", 64'(load_weight), 64'(0));
        chk("rst_issue_valid", 64'(issue_valid), 64'(0));
        chk("rst_w_ready", 64'(w_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        w_valid = 1'b0; a_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Weight tile with beat k element j = 16k+j
        for (int k = 0; k < ROWS; k++)
            for (int j = 0; j < COLS; j++) tile[k][j*DW +: DW] = 8'(16*k + j);
        load_tile();
        for (int k = 0; k < ROWS; k++) begin
            @(negedge clk);
            chk("lit_load_row", 64'(array_n), 64'(lit_rows[k]));
            chk("lit_load_weight", 64'(load_weight), 64'(1));
        end
        for (int k = 0; k < ROWS; k++) begin
            @(negedge clk);
            chk("lit_settle_zero", 64'({load_weight, array_n}), 64'(0));
        end
        chk("lit_stream_ready", 64'(a_ready), 64'(1));

        // Single vector [1,2,-3,-128] with a_last
        send_a(32'h80FD0201, 1'b1);
        chk("lit_vec_col0", 64'(array_n), 64'(32'h00000001));
        chk("lit_vec_issue", 64'({issue_valid, issue_last}), 64'(2'b11));
        @(negedge clk);
        chk("lit_vec_col1", 64'(array_n), 64'(32'h00000200));
        chk("lit_vec_issue_off", 64'(issue_valid), 64'(0));
        @(negedge clk);
        chk("lit_vec_col2", 64'(array_n), 64'(32'h00FD0000));
        @(negedge clk);
        chk("lit_vec_col3", 64'(array_n), 64'(32'h80000000));
        chk("lit_collect_again", 64'({busy, w_ready}), 64'(2'b01));

        // Bubbles: a_valid pattern 1,0,0,1,1
        rand_tile();
        load_tile();
        iv_count = 0;
        send_a($urandom, 1'b0);
        idle(2);
        send_a($urandom, 1'b0);
        send_a($urandom, 1'b1);
        idle(COLS + ROWS + 2);
        chk("bubble_issue_pulses", 64'(iv_count), 64'(3));

        // Protocol: w_valid held high while streaming, then a second tile
        rand_tile();
        load_tile();
        hold_w = 1'b1;
        stream_batch(3, 1'b0);
        hold_w = 1'b0;
        idle(10);
        rand_tile();
        load_tile();
        stream_batch(4, 1'b0);
        idle(10);

        // Golden run including -128 * -128
        rand_tile();
        tile[0][DW-1:0] = 8'h80;
        load_tile();
        stream_batch(8, 1'b1);
        idle(12);

        // Reset pulsed mid-LOAD, asynchronously
        rand_tile();
        load_tile();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_array_n", 64'(array_n), 64'(0));
        chk("async_rst_load_weight", 64'(load_weight), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_tile();
        tile[ROWS-1][VW-1 -: DW] = 8'h80;
        load_tile();
        stream_batch(8, 1'b1);
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
